// File: rtl/dec_fix_conv.sv
// Iterative decimal-to-fixed-point converter: one-hot/BCD digits in, signed Q(INT_BITS).(FRAC_BITS)
// out, with optional half-up rounding and saturation on overflow.
module dec_fix_conv #(
   parameter int unsigned INT_DIGITS  = 2,
   parameter int unsigned FRAC_DIGITS = 2,
   parameter int unsigned INT_BITS    = 7,
   parameter int unsigned FRAC_BITS   = 8,
   parameter int unsigned ONEHOT      = 1,
   localparam int unsigned DW = (ONEHOT != 0) ? 10 : 4,
   localparam int unsigned RW = 1 + INT_BITS + FRAC_BITS
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic                      neg,
   input  logic                      round_en,
   input  logic [INT_DIGITS*DW-1:0]  int_dig,
   input  logic [FRAC_DIGITS*DW-1:0] frac_dig,
   output logic                      busy,
   output logic                      done,
   output logic [RW-1:0]             result,
   output logic                      ovf,
   output logic                      err
);

   localparam int unsigned AW = INT_BITS + 4;
   localparam int unsigned MW = INT_BITS + FRAC_BITS;
   localparam int unsigned CW = $clog2(INT_DIGITS + FRAC_BITS + 1);

   typedef enum logic [2:0] {StIdle, StLoad, StInt, StFrac, StRound, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            neg_q, round_q, dig_err_q, sat_q;
   logic [AW-1:0]   acc_q;
   logic [FRAC_BITS-1:0] fbits_q;
   logic [MW:0]     mag_q;
   logic [3:0]      int_q  [INT_DIGITS];
   logic [3:0]      frac_q [FRAC_DIGITS];
   logic            busy_q, done_q, ovf_q, err_q;
   logic [RW-1:0]   result_q;

   logic [3:0]      int_dec  [INT_DIGITS];
   logic [3:0]      frac_dec [FRAC_DIGITS];
   logic            dig_err;
   logic [4:0]      dec;
   logic [3:0]      dbl      [FRAC_DIGITS];
   logic            dbl_cout;
   logic [4:0]      sum;
   logic            carry;
   logic [AW-1:0]   acc_nx;
   logic            int_last, frac_last;
   logic [MW:0]     rnd_inc;
   logic            ovf_nx;
   logic [MW:0]     mag_sat;

   // Returns {invalid, value}; invalid digits decode as zero.
   function automatic logic [4:0] decode(input logic [DW-1:0] d);
      logic [4:0]  r;
      int unsigned n;
      r = 5'b10000;
      n = 0;
      if (ONEHOT != 0) begin
         for (int k = 0; k < int'(DW); k++) begin
            if (d[k]) begin
               n++;
               r[3:0] = 4'(k);
            end
         end
         if (n == 1) r[4] = 1'b0;
         else        r = 5'b10000;
      end else if (d[3:0] <= 4'd9) begin
         r = {1'b0, d[3:0]};
      end
      return r;
   endfunction

   always_comb begin
      dig_err = 1'b0;
      dec     = '0;
      for (int i = 0; i < int'(INT_DIGITS); i++) begin
         dec        = decode(int_dig[i*DW +: DW]);
         int_dec[i] = dec[3:0];
         dig_err    = dig_err | dec[4];
      end
      for (int j = 0; j < int'(FRAC_DIGITS); j++) begin
         dec         = decode(frac_dig[j*DW +: DW]);
         frac_dec[j] = dec[3:0];
         dig_err     = dig_err | dec[4];
      end
   end

   // Doubling the BCD fraction; carry out of the tenths digit is the next binary fraction bit.
   always_comb begin
      carry = 1'b0;
      sum   = '0;
      for (int j = 0; j < int'(FRAC_DIGITS); j++) begin
         sum = {frac_q[j], 1'b0} + {4'b0, carry};
         if (sum >= 5'd10) begin
            sum   = sum - 5'd10;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         dbl[j] = sum[3:0];
      end
      dbl_cout = carry;
   end

   always_comb begin
      acc_nx    = acc_q * AW'(10) + AW'(int_q[INT_DIGITS-1]);
      int_last  = (cnt_q == CW'(INT_DIGITS - 1));
      frac_last = (cnt_q == CW'(FRAC_BITS - 1));
      rnd_inc   = {{MW{1'b0}}, round_q & dbl_cout};
      ovf_nx    = sat_q | mag_q[MW];
      mag_sat   = ovf_nx ? {1'b0, {MW{1'b1}}} : mag_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  state_d = StInt;
         StInt:   if (int_last) state_d = StFrac;
         StFrac:  if (frac_last) state_d = StRound;
         StRound: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         round_q   <= 1'b0;
         dig_err_q <= 1'b0;
         sat_q     <= 1'b0;
         acc_q     <= '0;
         fbits_q   <= '0;
         mag_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         result_q  <= '0;
         for (int i = 0; i < int'(INT_DIGITS); i++) int_q[i] <= '0;
         for (int j = 0; j < int'(FRAC_DIGITS); j++) frac_q[j] <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StIdle);
         done_q  <= (state_q == StDone);
         case (state_q)
            StIdle: begin
               if (start) begin
                  neg_q   <= neg;
                  round_q <= round_en;
               end
            end
            StLoad: begin
               int_q     <= int_dec;
               frac_q    <= frac_dec;
               dig_err_q <= dig_err;
               acc_q     <= '0;
               sat_q     <= 1'b0;
               fbits_q   <= '0;
               cnt_q     <= '0;
            end
            StInt: begin
               acc_q <= acc_nx;
               if (|acc_nx[AW-1:INT_BITS]) sat_q <= 1'b1;
               for (int i = int'(INT_DIGITS) - 1; i > 0; i--) int_q[i] <= int_q[i-1];
               int_q[0] <= '0;
               cnt_q    <= int_last ? '0 : cnt_q + CW'(1);
            end
            StFrac: begin
               frac_q  <= dbl;
               fbits_q <= {fbits_q[FRAC_BITS-2:0], dbl_cout};
               cnt_q   <= frac_last ? '0 : cnt_q + CW'(1);
            end
            StRound: mag_q <= {1'b0, acc_q[INT_BITS-1:0], fbits_q} + rnd_inc;
            StDone: begin
               result_q <= neg_q ? -mag_sat : mag_sat;
               ovf_q    <= ovf_nx;
               err_q    <= dig_err_q;
            end
            default: ;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign ovf    = ovf_q;
   assign err    = err_q;

endmodule

// File: tb/tb_dec_fix_conv.sv
// Directed bench for dec_fix_conv: default one-hot instance, INT_BITS=6 instance and BCD instance.
module tb_dec_fix_conv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        neg = 1'b0;
   logic        round_en = 1'b0;
   logic [19:0] id_m = '0, fd_m = '0, id_6 = '0, fd_6 = '0;
   logic [7:0]  id_b = '0, fd_b = '0;

   logic        busy_m, done_m, ovf_m, err_m;
   logic [15:0] res_m;
   logic        busy_6, done_6, ovf_6, err_6;
   logic [14:0] res_6;
   logic        busy_b, done_b, ovf_b, err_b;
   logic [15:0] res_b;

   int checks = 0;
   int errors = 0;
   int lat;
   int cnt;

   always #5 clk = ~clk;

   dec_fix_conv dut_m (
      .CLK(clk), .RST(rst), .start(start), .neg(neg), .round_en(round_en),
      .int_dig(id_m), .frac_dig(fd_m),
      .busy(busy_m), .done(done_m), .result(res_m), .ovf(ovf_m), .err(err_m)
   );

   dec_fix_conv #(.INT_BITS(6)) dut_6 (
      .CLK(clk), .RST(rst), .start(start), .neg(neg), .round_en(round_en),
      .int_dig(id_6), .frac_dig(fd_6),
      .busy(busy_6), .done(done_6), .result(res_6), .ovf(ovf_6), .err(err_6)
   );

   dec_fix_conv #(.ONEHOT(0)) dut_b (
      .CLK(clk), .RST(rst), .start(start), .neg(neg), .round_en(round_en),
      .int_dig(id_b), .frac_dig(fd_b),
      .busy(busy_b), .done(done_b), .result(res_b), .ovf(ovf_b), .err(err_b)
   );

   typedef struct {
      logic        neg;
      logic        rnd;
      logic [19:0] id;
      logic [19:0] fd;
      logic [15:0] res;
      logic        ovf;
      logic        err;
   } vec_t;

   vec_t tv [10];

   function automatic logic [9:0] oh1(input int d);
      logic [9:0] one;
      one = 10'd1;
      return one << d;
   endfunction

   function automatic logic [19:0] oh2(input int hi, input int lo);
      return {oh1(hi), oh1(lo)};
   endfunction

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", what, act, exp);
      end
   endtask

   // Waits up to 40 edges for done_m; lat counts edges after the start-sampling edge.
   task automatic wait_done(input int first, output int l);
      l = -1;
      for (int c = first; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (done_m) begin
            l = c;
            break;
         end
      end
   endtask

   task automatic run(output int l);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(1, l);
   endtask

   initial begin
      tv[0] = '{1'b0, 1'b0, oh2(1, 2), oh2(5, 0), 16'h0C80, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b0, oh2(1, 2), oh2(5, 0), 16'hF380, 1'b0, 1'b0};
      tv[2] = '{1'b1, 1'b0, oh2(0, 0), oh2(0, 0), 16'h0000, 1'b0, 1'b0};
      tv[3] = '{1'b0, 1'b0, oh2(0, 0), oh2(3, 5), 16'h0059, 1'b0, 1'b0};
      tv[4] = '{1'b0, 1'b1, oh2(0, 0), oh2(3, 5), 16'h005A, 1'b0, 1'b0};
      tv[5] = '{1'b0, 1'b0, oh2(9, 9), oh2(9, 9), 16'h63FD, 1'b0, 1'b0};
      tv[6] = '{1'b0, 1'b1, oh2(0, 1), oh2(0, 1), 16'h0103, 1'b0, 1'b0};
      tv[7] = '{1'b1, 1'b1, oh2(0, 1), oh2(0, 1), 16'hFEFD, 1'b0, 1'b0};
      tv[8] = '{1'b0, 1'b0, {oh1(1), 10'b0000000011}, oh2(5, 0), 16'h0A80, 1'b0, 1'b1};
      tv[9] = '{1'b0, 1'b0, oh2(0, 5), {10'b0, oh1(5)}, 16'h050C, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy_m), 32'd0);
      check("reset done", 32'(done_m), 32'd0);
      check("reset result", 32'(res_m), 32'd0);
      check("reset ovf", 32'(ovf_m), 32'd0);
      check("reset err", 32'(err_m), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         neg      = tv[i].neg;
         round_en = tv[i].rnd;
         id_m     = tv[i].id;
         fd_m     = tv[i].fd;
         run(lat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd13);
         check($sformatf("vec%0d result", i), 32'(res_m), 32'(tv[i].res));
         check($sformatf("vec%0d ovf", i), 32'(ovf_m), 32'(tv[i].ovf));
         check($sformatf("vec%0d err", i), 32'(err_m), 32'(tv[i].err));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d done pulse width", i), 32'(done_m), 32'd0);
      end

      // Saturating INT_BITS=6 instance and BCD instance alongside the main one.
      neg = 1'b0; round_en = 1'b0;
      id_m = oh2(1, 2); fd_m = oh2(5, 0);
      id_6 = oh2(7, 0); fd_6 = oh2(0, 0);
      id_b = {4'hC, 4'h3}; fd_b = {4'h5, 4'h0};
      run(lat);
      check("side latency", 32'(lat), 32'd13);
      check("int6 done", 32'(done_6), 32'd1);
      check("int6 70.00 result", 32'(res_6), 32'h3FFF);
      check("int6 70.00 ovf", 32'(ovf_6), 32'd1);
      check("bcd done", 32'(done_b), 32'd1);
      check("bcd C3.50 result", 32'(res_b), 32'h0380);
      check("bcd C3.50 err", 32'(err_b), 32'd1);
      check("bcd C3.50 ovf", 32'(ovf_b), 32'd0);

      id_6 = oh2(6, 3); fd_6 = oh2(9, 9);
      id_b = {4'h1, 4'h2}; fd_b = {4'h5, 4'h0};
      run(lat);
      check("int6 63.99 result", 32'(res_6), 32'h3FFD);
      check("int6 63.99 ovf", 32'(ovf_6), 32'd0);
      check("bcd 12.50 result", 32'(res_b), 32'h0C80);
      check("bcd 12.50 err", 32'(err_b), 32'd0);

      // start and input changes mid-run are ignored.
      neg = 1'b0; round_en = 1'b0;
      id_m = oh2(1, 2); fd_m = oh2(5, 0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check("busy after start", 32'(busy_m), 32'd1);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; neg = 1'b1; round_en = 1'b1;
      id_m = oh2(9, 9); fd_m = oh2(9, 9);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(6, lat);
      check("mid-start latency", 32'(lat), 32'd13);
      check("mid-start result", 32'(res_m), 32'h0C80);
      cnt = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done_m) cnt++;
      end
      check("mid-start no second done", 32'(cnt), 32'd0);

      // start held high: back-to-back conversions.
      neg = 1'b0; round_en = 1'b0;
      id_m = oh2(0, 0); fd_m = oh2(3, 5);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      wait_done(1, lat);
      check("held first latency", 32'(lat), 32'd13);
      check("held first result", 32'(res_m), 32'h0059);
      wait_done(14, lat);
      start = 1'b0;
      check("held second latency", 32'(lat), 32'd27);
      check("held second result", 32'(res_m), 32'h0059);

      // Reset mid-conversion.
      id_m = oh2(1, 2); fd_m = oh2(5, 0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort busy", 32'(busy_m), 32'd0);
      check("abort result", 32'(res_m), 32'd0);
      check("abort done", 32'(done_m), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done_m) cnt++;
      end
      check("abort no done", 32'(cnt), 32'd0);
      check("abort idle busy", 32'(busy_m), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
